// File: rtl/scancode_sequencer_if.sv
// Byte-stream, frame-sync and character-register signals shared between the
// scancode sequencer and its neighbours.
interface scancode_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       vsync_start;
    logic [7:0] scancode;
    logic       enable;
    logic       key_held;
    logic       pending;
    logic       prefix_timeout;

    modport master (
        output rx_data, rx_valid, vsync_start,
        input  scancode, enable, key_held, pending, prefix_timeout
    );

    modport slave (
        input  rx_data, rx_valid, vsync_start,
        output scancode, enable, key_held, pending, prefix_timeout
    );
endinterface

// File: rtl/scancode_sequencer.sv
// Decodes PS/2 make/break/extended scancodes, drops typematic repeats and defers
// each accepted key to the start of vertical blanking before driving the char register.
module scancode_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input logic                  clk,
    input logic                  reset,
    scancode_sequencer_if.slave  bus
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          state;
    logic [7:0]      held_code;
    logic [7:0]      pend_code;
    logic            pend_valid;
    logic [CntW-1:0] cnt;
    logic [7:0]      scancode;
    logic            enable;
    logic            key_held;
    logic            prefix_timeout;

    logic is_accept;
    logic new_make;

    assign is_accept = (bus.rx_data == 8'h2B) || (bus.rx_data == 8'h15) ||
                       (bus.rx_data == 8'h33) || (bus.rx_data == 8'h22);
    assign new_make  = bus.rx_valid && (state == StIdle) && is_accept &&
                       (bus.rx_data != held_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            held_code      <= 8'h00;
            pend_code      <= 8'h00;
            pend_valid     <= 1'b0;
            cnt            <= '0;
            scancode       <= 8'h00;
            enable         <= 1'b0;
            key_held       <= 1'b0;
            prefix_timeout <= 1'b0;
        end else begin
            enable         <= 1'b0;
            prefix_timeout <= 1'b0;

            if (bus.vsync_start && pend_valid) begin
                scancode   <= pend_code;
                enable     <= 1'b1;
                pend_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (bus.rx_valid) begin
                        if (bus.rx_data == 8'hE0) begin
                            state <= StExt;
                        end else if (bus.rx_data == 8'hF0) begin
                            state <= StBrk;
                        end else if (new_make) begin
                            held_code <= bus.rx_data;
                            key_held  <= 1'b1;
                            pend_code <= bus.rx_data;
                            // A make landing on the vsync cycle bypasses the pending slot.
                            if (bus.vsync_start) begin
                                scancode   <= bus.rx_data;
                                enable     <= 1'b1;
                                pend_valid <= 1'b0;
                            end else begin
                                pend_valid <= 1'b1;
                            end
                        end
                    end
                end
                StExt, StBrk, StExtBrk: begin
                    if (bus.rx_valid) begin
                        cnt <= '0;
                        if (state == StExt && bus.rx_data == 8'hF0) begin
                            state <= StExtBrk;
                        end else begin
                            state <= StIdle;
                        end
                        if (state == StBrk && bus.rx_data == held_code) begin
                            held_code <= 8'h00;
                            key_held  <= 1'b0;
                        end
                    end else if (cnt == CntLast) begin
                        state          <= StIdle;
                        cnt            <= '0;
                        prefix_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.scancode       = scancode;
    assign bus.enable         = enable;
    assign bus.key_held       = key_held;
    assign bus.pending        = pend_valid;
    assign bus.prefix_timeout = prefix_timeout;
endmodule

// File: tb/tb_scancode_sequencer.sv
// Scoreboarded random/directed bench for scancode_sequencer against a
// prefix-queue reference model of the key decoding and vblank commit rules.
module tb_scancode_sequencer;
    localparam int unsigned T = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scancode_sequencer_if bus ();

    scancode_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int enable_count = 0;
    int tout_count = 0;

    logic [7:0] exp_q[$];

    // Reference model: pending prefix bytes kept as a queue.
    logic [7:0] m_prefix[$];
    logic [7:0] m_held, m_pend, m_code;
    bit         m_pvalid, m_tout;
    int         m_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit accepted(input logic [7:0] b);
        return (b == 8'h2B) || (b == 8'h15) || (b == 8'h33) || (b == 8'h22);
    endfunction

    task automatic model_reset();
        m_prefix.delete();
        m_held = 8'h00; m_pend = 8'h00; m_code = 8'h00;
        m_pvalid = 1'b0; m_tout = 1'b0; m_wait = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit rv, input logic [7:0] b, input bit vs);
        bit newmake;
        newmake = 1'b0;
        m_tout = 1'b0;
        if (rv) begin
            m_wait = 0;
            if (m_prefix.size() == 0) begin
                if (b == 8'hE0 || b == 8'hF0) m_prefix.push_back(b);
                else if (accepted(b) && b != m_held) begin
                    m_held = b;
                    newmake = 1'b1;
                end
            end else if (m_prefix.size() == 1 && m_prefix[0] == 8'hE0 && b == 8'hF0) begin
                m_prefix.push_back(b);
            end else begin
                if (m_prefix.size() == 1 && m_prefix[0] == 8'hF0 && b == m_held) m_held = 8'h00;
                m_prefix.delete();
            end
        end else if (m_prefix.size() != 0) begin
            m_wait++;
            if (m_wait == int'(T)) begin
                m_prefix.delete();
                m_wait = 0;
                m_tout = 1'b1;
            end
        end
        if (newmake && vs) begin
            m_code = b;
            exp_q.push_back(b);
            m_pvalid = 1'b0;
        end else begin
            if (vs && m_pvalid) begin
                m_code = m_pend;
                exp_q.push_back(m_pend);
                m_pvalid = 1'b0;
            end
            if (newmake) begin
                m_pend = b;
                m_pvalid = 1'b1;
            end
        end
    endtask

    // One cycle: check state produced by the previous cycle, then drive this one.
    task automatic step(input bit rv, input logic [7:0] b, input bit vs);
        @(negedge clk);
        chk("key_held", 32'(bus.key_held), 32'(m_held != 8'h00));
        chk("pending", 32'(bus.pending), 32'(m_pvalid));
        chk("scancode", 32'(bus.scancode), 32'(m_code));
        chk("prefix_timeout", 32'(bus.prefix_timeout), 32'(m_tout));
        chk("commit_latency", 32'(exp_q.size()), 32'd0);
        bus.rx_valid    = rv;
        bus.rx_data     = rv ? b : 8'h00;
        bus.vsync_start = vs;
        model_step(rv, b, vs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic vsync();
        step(1'b0, 8'h00, 1'b1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes enable.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            if (bus.prefix_timeout) tout_count++;
            if (bus.enable) begin
                logic [7:0] e;
                enable_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_enable: scancode %0h, nothing expected at %0t",
                             bus.scancode, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.scancode !== e) begin
                        errors++;
                        $display("FAIL commit_code: got %0h expected %0h at %0t",
                                 bus.scancode, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        int en0, pick;
        logic [7:0] accs [4];
        logic [7:0] b;
        bit rv, vs;
        accs[0] = 8'h2B; accs[1] = 8'h15; accs[2] = 8'h33; accs[3] = 8'h22;

        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.vsync_start = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_scancode", 32'(bus.scancode), 32'h00);
        chk("reset_enable", 32'(bus.enable), 32'd0);
        reset = 1'b1;

        // Basic commit
        send(8'h2B);
        idle(99);
        chk("basic_pending", 32'(bus.pending), 32'd1);
        vsync();
        idle(1);
        chk("basic_scancode", 32'(bus.scancode), 32'h2B);
        chk("basic_enable", 32'(bus.enable), 32'd1);
        chk("basic_held", 32'(bus.key_held), 32'd1);
        idle(1);
        chk("basic_enable_fall", 32'(bus.enable), 32'd0);

        // Typematic repeat
        en0 = enable_count;
        send(8'h15); vsync(); send(8'h15); send(8'h15); vsync(); idle(2);
        chk("typematic_one_enable", 32'(enable_count - en0), 32'd1);
        send(8'hF0); send(8'h15); idle(1);
        chk("break_released", 32'(bus.key_held), 32'd0);
        send(8'h15); vsync(); idle(2);
        chk("typematic_second_enable", 32'(enable_count - en0), 32'd2);

        // Overwrite then simultaneous
        en0 = enable_count;
        send(8'h33); send(8'h22); idle(3); vsync(); idle(2);
        chk("overwrite_one_enable", 32'(enable_count - en0), 32'd1);
        chk("overwrite_code", 32'(bus.scancode), 32'h22);
        step(1'b1, 8'h2B, 1'b1);
        idle(1);
        chk("simul_enable", 32'(bus.enable), 32'd1);
        chk("simul_code", 32'(bus.scancode), 32'h2B);
        chk("simul_pending", 32'(bus.pending), 32'd0);

        // Prefixes
        en0 = enable_count;
        send(8'hE0); send(8'h2B); send(8'hE0); send(8'hF0); send(8'h2B);
        send(8'hF0); send(8'h33); vsync(); idle(2);
        chk("prefix_no_enable", 32'(enable_count - en0), 32'd0);
        chk("prefix_code", 32'(bus.scancode), 32'h2B);
        chk("prefix_still_held", 32'(bus.key_held), 32'd1);
        send(8'h15); idle(1);
        chk("prefix_back_idle", 32'(bus.pending), 32'd1);
        vsync(); idle(2);

        // Timeout
        en0 = tout_count;
        send(8'hF0); idle(T + 2);
        chk("timeout_once", 32'(tout_count - en0), 32'd1);
        send(8'h2B); idle(1);
        chk("after_timeout_make", 32'(bus.pending), 32'd1);
        vsync(); idle(2);

        // Asynchronous reset with a code pending
        send(8'h22); idle(2);
        en0 = enable_count;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_pending", 32'(bus.pending), 32'd0);
        chk("rst_async_held", 32'(bus.key_held), 32'd0);
        chk("rst_async_code", 32'(bus.scancode), 32'h00);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        vsync(); idle(2);
        chk("rst_no_enable", 32'(enable_count - en0), 32'd0);
        chk("rst_code", 32'(bus.scancode), 32'h00);

        // Random traffic with occasional quiet stretches for timeouts
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                idle(T + 5);
            end else begin
                rv = ($urandom_range(0, 1) == 1);
                pick = $urandom_range(0, 9);
                if (pick <= 4) b = accs[$urandom_range(0, 3)];
                else if (pick == 5) b = 8'hE0;
                else if (pick == 6) b = 8'hF0;
                else if (pick == 7) b = m_held;
                else b = 8'($urandom);
                vs = ($urandom_range(0, 24) == 0);
                step(rv, b, vs);
            end
        end
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
